// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

   localparam int unsigned NIB_W            = 4;
   localparam int unsigned MAX_DIGITS       = 8;
   localparam int unsigned CLK_DIV_DEF      = 50000;
   localparam int unsigned BLANK_CYCLES_DEF = 500;

   // All anodes off (active-low enables); slice to the digit count in use.
   localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_ON    = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot counter: counts 0..CLK_DIV-1 while enabled, flags the wrap
// cycle and the frame boundary (wrap on the last digit).
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF,
   localparam int unsigned CNT_W  = $clog2(CLK_DIV)
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   input  logic             en,
   input  logic             last_digit,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap_c,
   output logic             boundary_c
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   assign wrap_c     = en && (cnt == CNT_LAST);
   assign boundary_c = wrap_c && last_digit;

   // Slot counter; held at zero while scanning is disabled.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt <= '0;
      end else if (!en || wrap_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Holds a double-buffered hex value, committed at frame boundaries, and
// drives one active-low anode per digit slot after a blanking interval.
// Optional build macro: LEAD_ZERO_BLANK_EN (suppress leading-zero digits).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned CLK_DIV      = CLK_DIV_DEF,
   parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF
) (
   input  logic                        HCLK,
   input  logic                        HRESETn,
   input  logic                        scan_en,
   input  logic                        value_we,
   input  logic [NIB_W*NUM_DIGITS-1:0] value_in,
   output logic [NIB_W-1:0]            nibble_out,
   output logic [NUM_DIGITS-1:0]       an_n,
   output logic [2:0]                  digit_idx,
   output logic                        frame_done,
   output logic                        pending
);

   localparam int unsigned VAL_W    = NIB_W * NUM_DIGITS;
   localparam int unsigned CNT_W    = $clog2(CLK_DIV);
   localparam logic [2:0]  LAST_DIG = 3'(NUM_DIGITS - 1);

   scan_state_e            state_q;
   scan_state_e            state_d;
   logic [CNT_W-1:0]       cnt;
   logic                   wrap_c;
   logic                   boundary_c;
   logic                   last_digit_c;

   logic [VAL_W-1:0]       active_q;
   logic [VAL_W-1:0]       active_d;
   logic [VAL_W-1:0]       shadow_q;
   logic [VAL_W-1:0]       shadow_d;
   logic                   pending_d;
   logic [2:0]             digit_d;
   logic [NIB_W-1:0]       nib_d;
   logic [NUM_DIGITS-1:0]  an_d;
   logic                   lit_c;

   assign last_digit_c = (digit_idx == LAST_DIG);

   seg_scan_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .en         (scan_en),
      .last_digit (last_digit_c),
      .cnt        (cnt),
      .wrap_c     (wrap_c),
      .boundary_c (boundary_c)
   );

`ifdef LEAD_ZERO_BLANK_EN
   // Index of the most significant nonzero digit; 0 when the value is zero.
   function automatic logic [2:0] lead_digit(input logic [VAL_W-1:0] v);
      lead_digit = '0;
      for (int i = 1; i < int'(NUM_DIGITS); i++) begin
         if (v[NIB_W*i +: NIB_W] != '0) lead_digit = 3'(i);
      end
   endfunction
`endif

   // FSM state register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= S_BLANK;
      else          state_q <= state_d;
   end

   // Next state: blank for the first BLANK_CYCLES of each slot, then on.
   always_comb begin
      state_d = state_q;
      if (!scan_en) begin
         state_d = S_BLANK;
      end else if (wrap_c) begin
         state_d = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;
      end else if (state_q == S_BLANK && (32'(cnt) + 32'd1 >= BLANK_CYCLES)) begin
         state_d = S_ON;
      end
   end

   // Buffer commit, digit advance and next registered output values.
   always_comb begin
      shadow_d  = value_we ? value_in : shadow_q;
      active_d  = active_q;
      pending_d = pending;
      digit_d   = digit_idx;
      an_d      = ANODE_OFF[NUM_DIGITS-1:0];
      lit_c     = 1'b1;

      // Commit at a frame boundary or any time the display is dark;
      // a write in that same cycle bypasses the shadow.
      if (boundary_c || !scan_en) begin
         pending_d = 1'b0;
         if (value_we)     active_d = value_in;
         else if (pending) active_d = shadow_q;
      end else if (value_we) begin
         pending_d = 1'b1;
      end

      if (!scan_en) begin
         digit_d = '0;
      end else if (wrap_c) begin
         digit_d = last_digit_c ? 3'd0 : digit_idx + 3'd1;
      end

      nib_d = NIB_W'(active_d >> (32'(digit_d) * NIB_W));

`ifdef LEAD_ZERO_BLANK_EN
      lit_c = (digit_d <= lead_digit(active_d));
`else
      lit_c = 1'b1;
`endif

      if (state_d == S_ON && lit_c) begin
         an_d = ~(NUM_DIGITS'(1) << digit_d);
      end
   end

   // Registered outputs and value buffers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         active_q   <= '0;
         shadow_q   <= '0;
         pending    <= 1'b0;
         digit_idx  <= '0;
         nibble_out <= '0;
         an_n       <= ANODE_OFF[NUM_DIGITS-1:0];
         frame_done <= 1'b0;
      end else begin
         active_q   <= active_d;
         shadow_q   <= shadow_d;
         pending    <= pending_d;
         digit_idx  <= digit_d;
         nibble_out <= nib_d;
         an_n       <= an_d;
         frame_done <= boundary_c;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-time reference model pushes
// the expected outputs per clock edge; a monitor pops and compares them.
module tb_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int CD    = 8;
   localparam int BL    = 2;
   localparam int FRAME = ND * CD;

   logic        clk;
   logic        rst_n;
   logic        scan_en;
   logic        value_we;
   logic [15:0] value_in;
   logic [3:0]  nibble_out;
   logic [3:0]  an_n;
   logic [2:0]  digit_idx;
   logic        frame_done;
   logic        pending;

   seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .CLK_DIV      (CD),
      .BLANK_CYCLES (BL)
   ) dut (
      .HCLK       (clk),
      .HRESETn    (rst_n),
      .scan_en    (scan_en),
      .value_we   (value_we),
      .value_in   (value_in),
      .nibble_out (nibble_out),
      .an_n       (an_n),
      .digit_idx  (digit_idx),
      .frame_done (frame_done),
      .pending    (pending)
   );

   typedef struct {
      int         edge_no;
      logic [3:0] an;
      logic [3:0] nib;
      logic [2:0] dig;
      logic       fd;
      logic       pend;
   } exp_t;

   exp_t q[$];
   int   edge_cnt = 0;
   int   n_vec    = 0;
   int   n_bad    = 0;

   // Reference model: position within the frame plus the displayed value.
   int          m_t;
   logic [15:0] m_disp;
   logic [15:0] m_shadow;
   bit          m_pend;
   bit          m_fd;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt++;

   function automatic bit digit_lit(input int dig, input logic [15:0] v);
`ifdef LEAD_ZERO_BLANK_EN
      int top = 0;
      for (int i = 1; i < ND; i++)
         if (((v >> (4 * i)) & 16'hF) != 16'h0) top = i;
      return dig <= top;
`else
      return 1'b1;
`endif
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int   pos = m_t % CD;
      int   dig = m_t / CD;
      logic [15:0] sh = m_disp >> (4 * dig);
      e.edge_no = 0;
      e.dig  = 3'(dig);
      e.nib  = sh[3:0];
      e.an   = (pos < BL || !digit_lit(dig, m_disp)) ? 4'hF : ~(4'b0001 << dig);
      e.fd   = m_fd;
      e.pend = m_pend;
      return e;
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.edge_no = 0;
      e.an = 4'hF; e.nib = 4'h0; e.dig = 3'd0; e.fd = 1'b0; e.pend = 1'b0;
      return e;
   endfunction

   task automatic model_reset();
      m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_fd = 0;
   endtask

   task automatic check(input string nm, input exp_t e);
      n_vec++;
      if (an_n !== e.an || nibble_out !== e.nib || digit_idx !== e.dig ||
          frame_done !== e.fd || pending !== e.pend) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got an_n=%b nib=%h dig=%0d fd=%b pend=%b, want an_n=%b nib=%h dig=%0d fd=%b pend=%b",
                  nm, edge_cnt, an_n, nibble_out, digit_idx, frame_done, pending,
                  e.an, e.nib, e.dig, e.fd, e.pend);
      end
   endtask

   // Monitor: compare every expectation whose clock edge has passed.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
            e = q.pop_front();
            check("scan", e);
         end
      end
   end

   // Apply one cycle of inputs, advance the model, queue the expectation.
   task automatic step(input bit en, input bit we, input logic [15:0] v);
      exp_t e;
      bit   bnd;
      scan_en  = en;
      value_we = we;
      value_in = v;
      if (!en) begin
         m_t  = 0;
         m_fd = 0;
         if (we) begin
            m_shadow = v;
            m_disp   = v;
         end else if (m_pend) begin
            m_disp = m_shadow;
         end
         m_pend = 0;
      end else begin
         bnd  = (m_t == FRAME - 1);
         m_fd = bnd;
         if (bnd) begin
            if (we)          m_disp = v;
            else if (m_pend) m_disp = m_shadow;
            m_pend = 0;
         end else if (we) begin
            m_pend = 1;
         end
         if (we) m_shadow = v;
         m_t = (m_t + 1) % FRAME;
      end
      e = model_out();
      e.edge_no = edge_cnt + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 16'h0);
   endtask

   // Scan forward (bounded) until the model reaches frame position tgt.
   task automatic go_to(input int tgt);
      for (int i = 0; i < 2 * FRAME && m_t != tgt; i++) step(1, 0, 16'h0);
   endtask

   // Short reset pulse released before the next clock edge.
   task automatic reset_pulse();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("async_reset", reset_exp());
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      scan_en  = 1'b0;
      value_we = 1'b0;
      value_in = '0;
      model_reset();
      @(negedge clk);
      check("reset", reset_exp());
      #2 rst_n = 1'b1;

      // Load 0x1234 while dark, then scan two frames.
      step(0, 1, 16'h1234);
      step(0, 0, 16'h0);
      run(2 * FRAME + 4);

      // Mid-frame write waits for the boundary.
      go_to(12);
      step(1, 1, 16'hABCD);
      run(FRAME + 10);

      // Two writes in one frame: only the last commits.
      go_to(3);
      step(1, 1, 16'h1111);
      run(5);
      step(1, 1, 16'h2222);
      run(FRAME + 4);

      // Write in the exact boundary cycle bypasses the shadow.
      go_to(FRAME - 1);
      step(1, 1, 16'h5555);
      run(FRAME + 2);

      // Drop scan_en mid-slot on digit 2, with a write while dark.
      go_to(2 * CD + 4);
      for (int i = 0; i < 5; i++) step(0, (i == 2), 16'h9876);
      run(FRAME + 6);

      // Async reset mid-slot, then recover.
      go_to(CD + 5);
      reset_pulse();
      run(4);
      step(1, 1, 16'h0C0F);
      run(2 * FRAME);

      // Leading-zero values.
      step(1, 1, 16'h0040);
      run(2 * FRAME);
      step(1, 1, 16'h0000);
      run(2 * FRAME);

      // Randomised traffic.
      for (int i = 0; i < 900; i++) begin
         bit          en = ($urandom_range(0, 49) != 0);
         bit          we = ($urandom_range(0, 11) == 0);
         logic [15:0] v  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
         step(en, we, v);
         if (i == 450) reset_pulse();
      end

      @(negedge clk);
      #1;
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display on the FPGA board. It holds a hex value and selects one digit at a time. For the selected digit it presents that digit's nibble to the downstream 7-segment decoder and drives the matching active-low anode enable. Value updates from the AHB register slave are double-buffered and committed only at frame boundaries, so a write never shows a half-updated display. A blanking interval between digits suppresses ghosting.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal range 1..8)
CLK_DIV, 50000, HCLK cycles per digit slot (minimum 2)
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off (must be less than CLK_DIV; 0 is legal)

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
scan_en  in  1  high = scanning; low = display dark, scan held at digit 0
value_we  in  1  one-cycle write strobe for value_in
value_in  in  4*NUM_DIGITS  hex value; digit i = value_in[4i+3:4i]
nibble_out  out  4  nibble for the 7-segment decoder
an_n  out  NUM_DIGITS  active-low digit anode enables
digit_idx  out  3  index of the current digit
frame_done  out  1  one-cycle pulse after each complete frame
pending  out  1  a written value is waiting for commit

Behaviour:
- Reset (async assert, sync release): an_n all 1; nibble_out 0; digit_idx 0; slot counter 0; state S_BLANK; active and shadow registers 0; pending 0; frame_done 0.
- Slot counter counts 0..CLK_DIV-1 while scan_en=1, then wraps.
- FSM states:
  - S_BLANK: counter < BLANK_CYCLES; an_n all 1.
  - S_ON: remaining cycles of the slot; an_n[digit_idx]=0, all other anodes 1.
  - With BLANK_CYCLES=0, S_ON starts on the first slot cycle.
- On counter wrap:
  - digit_idx advances (NUM_DIGITS-1 wraps to 0).
  - nibble_out is registered from the active register for the new digit in the same cycle digit_idx changes, so it is stable before the anode turns on.
- All outputs are registered. An anode turns on exactly BLANK_CYCLES cycles after digit_idx changes.
- Frame boundary: the cycle in which the counter wraps with digit_idx = NUM_DIGITS-1.
  - If pending=1, active <= shadow and pending is cleared.
  - frame_done pulses high in the following cycle.
- Writes:
  - value_we loads shadow <= value_in and sets pending, in any cycle.
  - Back-to-back writes before a boundary: only the last one is committed.
  - Write in the boundary cycle itself: active <= value_in directly (bypass) and pending ends at 0.
- scan_en low:
  - Next cycle: an_n all 1; counter and digit_idx forced to 0; state S_BLANK; no frame_done.
  - Writes are still accepted into shadow.
  - While scan_en is low, a pending value commits immediately (the display is dark, so there is no tearing).
- scan_en rising: scanning restarts at digit 0, counter 0, S_BLANK.
- Reset mid-frame: all state returns to reset values immediately; any pending write is lost.

Optional Feature:
Macro LEAD_ZERO_BLANK_EN.
- Defined: digits above the most significant nonzero digit of the active value keep their anode off during S_ON. Digit 0 is always shown. Timing, digit_idx and frame_done are unchanged. Example: value 0x0040 lights digits 1 and 0 only.
- Undefined: every digit is lit in its S_ON phase, including leading zeros.

Decomposition:
- Shared package seg_pkg:
  - state enum (S_BLANK, S_ON)
  - default constants for CLK_DIV and BLANK_CYCLES
  - ANODE_OFF all-ones helper
  - nibble width constant (4)
- Sub-module seg_scan_timer: slot counter plus wrap and boundary flags, parameterised by CLK_DIV.
- The FSM, buffering and anode logic stay in seg_scan_ctrl.
- The 7-segment decoder is instantiated by the parent, not inside this block.

Test Plan:
Bench parameters: NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2 (frame = 32 cycles).
1. Reset, scan_en=1, initial value 0x1234 written while scan_en=0 -> over one frame, digit_idx steps 0,1,2,3 every 8 cycles; nibble_out 4,3,2,1; an_n 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles; frame_done pulses once per 32 cycles.
2. Write 0xABCD mid-frame -> pending=1; display keeps showing 0x1234 until the boundary; next frame shows D,C,B,A; pending returns to 0.
3. Writes 0x1111 then 0x2222 in the same frame -> the next frame shows only 2222.
4. Write 0x5555 in the exact boundary cycle -> the next frame shows 5555; pending is 0 after that cycle.
5. Drop scan_en for 5 cycles mid-slot on digit 2 -> an_n becomes 1111 the next cycle; after re-assert, the scan restarts at digit 0 with a 2-cycle blank; HRESETn pulse mid-slot -> all outputs return to reset values asynchronously.
6. With LEAD_ZERO_BLANK_EN defined, value 0x0040 -> an_n stays 1111 during S_ON of digits 3 and 2; digits 1 and 0 light. Value 0x0000 -> only digit 0 lights.
